// File: rtl/score_bcd_display_if.sv
// Bus between the score counter and the BCD/seven-segment converter.
// The master drives value/load; the slave (converter) drives the results.
interface score_bcd_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                ovf;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] hex;

    modport master (output value, load, input busy, done, ovf, bcd, hex);
    modport slave  (input value, load, output busy, done, ovf, bcd, hex);
endinterface

// File: rtl/score_bcd_display.sv
// Sequential double-dabble binary->BCD converter driving active-low HEX displays.
// Define SCORE_BCD_DISPLAY_BLANK_EN to blank leading zeros on hex.
module score_bcd_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic              clk,
    input  logic              reset,
    score_bcd_display_if.slave bus
);

    function automatic int dec_digits(input int w);
        longint unsigned v;
        int n;
        v = (64'd1 << w) - 64'd1;
        n = 1;
        while (v >= 64'd10) begin
            v = v / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int ACC_DIGITS = dec_digits(WIDTH);
    localparam int MAXD       = (ACC_DIGITS > DIGITS) ? ACC_DIGITS : DIGITS;
    localparam int CW         = $clog2(WIDTH + 1);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    function automatic logic [7*DIGITS-1:0] reset_hex();
        logic [7*DIGITS-1:0] r;
`ifdef SCORE_BCD_DISPLAY_BLANK_EN
        r      = {DIGITS{7'b1111111}};
        r[6:0] = 7'b1000000;
`else
        r      = {DIGITS{7'b1000000}};
`endif
        return r;
    endfunction

    localparam logic [7*DIGITS-1:0] HEX_RST = reset_hex();

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-1:0]        sr_q, sr_d;
    logic [4*ACC_DIGITS-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*DIGITS-1:0]     bcd_q, bcd_d;
    logic [7*DIGITS-1:0]     hex_q, hex_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;

    logic [4*ACC_DIGITS-1:0] adj;
    logic [4*MAXD-1:0]       ext;
    logic                    over;
    logic [4*DIGITS-1:0]     res_bcd;
    logic [7*DIGITS-1:0]     res_hex;

    // Result formatting from the finished accumulator; digits beyond DIGITS mean overflow.
    always_comb begin
        ext  = (4*MAXD)'(acc_q);
        over = 1'b0;
        for (int unsigned i = DIGITS; i < MAXD; i++) begin
            if (ext[i*4 +: 4] != 4'd0) over = 1'b1;
        end
        res_bcd = over ? {DIGITS{4'h9}} : ext[4*DIGITS-1:0];
        res_hex = '1;
`ifdef SCORE_BCD_DISPLAY_BLANK_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                int unsigned idx;
                idx = DIGITS - 1 - k;
                if (res_bcd[idx*4 +: 4] != 4'd0 || idx == 0) seen = 1'b1;
                res_hex[idx*7 +: 7] = seen ? seg7(res_bcd[idx*4 +: 4]) : 7'b1111111;
            end
        end
`else
        for (int unsigned i = 0; i < DIGITS; i++) begin
            res_hex[i*7 +: 7] = seg7(res_bcd[i*4 +: 4]);
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        adj     = acc_q;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    sr_d    = bus.value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                for (int unsigned i = 0; i < ACC_DIGITS; i++) begin
                    if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
                end
                {acc_d, sr_d} = {adj, sr_q} << 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                bcd_d   = res_bcd;
                hex_d   = res_hex;
                ovf_d   = over;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            hex_q   <= HEX_RST;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;
    assign bus.bcd  = bcd_q;
    assign bus.hex  = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench: two converters (3 and 2 digits) fed the same stimulus,
// compared against an arithmetic decimal/segment model.
module tb_score_bcd_display;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load = 1'b0;
    logic [7:0] value = '0;
    int         n_tests = 0;
    int         n_fail = 0;

    score_bcd_display_if #(.WIDTH(8), .DIGITS(3)) ia ();
    score_bcd_display_if #(.WIDTH(8), .DIGITS(2)) ib ();

    assign ia.load  = load;
    assign ia.value = value;
    assign ib.load  = load;
    assign ib.value = value;

    score_bcd_display #(.WIDTH(8), .DIGITS(3)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
    score_bcd_display #(.WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return tbl[d];
    endfunction

    function automatic int pow10(input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [63:0] m_bcd(input int v, input int d);
        logic [63:0] r = '0;
        int lim = pow10(d) - 1;
        for (int i = 0; i < d; i++)
            r[i*4 +: 4] = (v > lim) ? 4'd9 : 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic logic [63:0] m_hex(input int v, input int d);
        logic [63:0] r = '0;
        int lim = pow10(d) - 1;
        for (int i = 0; i < d; i++) begin
            r[i*7 +: 7] = seg_of((v > lim) ? 9 : (v / pow10(i)) % 10);
`ifdef SCORE_BCD_DISPLAY_BLANK_EN
            if (v <= lim && i > 0 && v < pow10(i)) r[i*7 +: 7] = 7'b1111111;
`endif
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int v);
        check({tag, "_bcd_a"}, 64'(ia.bcd), m_bcd(v, 3));
        check({tag, "_hex_a"}, 64'(ia.hex), m_hex(v, 3));
        check({tag, "_ovf_a"}, 64'(ia.ovf), 64'(v > 999));
        check({tag, "_bcd_b"}, 64'(ib.bcd), m_bcd(v, 2));
        check({tag, "_hex_b"}, 64'(ib.hex), m_hex(v, 2));
        check({tag, "_ovf_b"}, 64'(ib.ovf), 64'(v > 99));
    endtask

    // Load issued for exactly one edge N; returns just after edge N+9.
    task automatic convert(input int v);
        value = 8'(v);
        load  = 1'b1;
        tick();
        load  = 1'b0;
        value = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            check("busy_a", 64'(ia.busy), 64'd1);
            check("busy_b", 64'(ib.busy), 64'd1);
            check("early_done", 64'(ia.done | ib.done), 64'd0);
            if (k != 7) tick();
        end
        tick();
        check("busy_last_a", 64'(ia.busy), 64'd0);
        check("done_last", 64'(ia.done | ib.done), 64'd0);
        tick();
        check("done_a", 64'(ia.done), 64'd1);
        check("done_b", 64'(ib.done), 64'd1);
        check("busy_done", 64'(ia.busy | ib.busy), 64'd0);
        check_results($sformatf("conv%0d", v), v);
    endtask

    initial begin
        int last;
        int dones;

        tick();
        check("rst_busy", 64'(ia.busy | ib.busy), 64'd0);
        check("rst_done", 64'(ia.done | ib.done), 64'd0);
        check_results("rst", 0);
        reset = 1'b1;
        tick();

        convert(0);
        convert(255);
        convert(7);
        convert(200);
        convert(12);
        convert(99);
        convert(100);
        for (int i = 0; i < 6; i++) begin
            last = int'($urandom_range(0, 255));
            convert(last);
        end

        repeat (3) tick();
        check("hold_done", 64'(ia.done | ib.done), 64'd0);
        check_results("hold", last);

        // Second load during SHIFT must be dropped
        value = 8'd42;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (2) tick();
        value = 8'd99;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ia.done) dones++;
        end
        check("ignore_dones", 64'(dones), 64'd1);
        check("ignore_busy", 64'(ia.busy | ib.busy), 64'd0);
        check_results("ignore", 42);

        // Reset mid-conversion
        value = 8'd200;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", 64'(ia.busy | ib.busy), 64'd0);
        check("abort_done", 64'(ia.done | ib.done), 64'd0);
        check_results("abort", 0);
        tick();
        tick();
        reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ia.done || ib.done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        check_results("abort_hold", 0);
        convert(13);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
